snake_food_spawner: RTL and testbench

SNAKE_FOOD_SPAWNER -- requirements
Module: snake_food_spawner

---
 rtl/snake_pkg.sv | 23 ++
 rtl/snake_lfsr16.sv | 15 +
 rtl/snake_food_spawner.sv | 170 +++++++++++++++++
 tb/tb_snake_food_spawner.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants and types for the snake food spawner slice.
package snake_pkg;

  localparam int unsigned DEF_GRID_W = 40;
  localparam int unsigned DEF_GRID_H = 30;
  localparam int unsigned DEF_X_W    = 6;
  localparam int unsigned DEF_Y_W    = 5;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois taps for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned FOOD_RST_X = 24;
  localparam int unsigned FOOD_RST_Y = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GEN,
    S_QUERY,
    S_PLACE
  } spawn_state_t;

endpackage

// File: rtl/snake_lfsr16.sv
// Free-running 16-bit Galois LFSR; maximal length, so it never reaches zero from a nonzero seed.
module snake_lfsr16
  import snake_pkg::*;
(
  input  logic        CLK_50M,
  input  logic        RSTn,
  output logic [15:0] lfsr
);

  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) lfsr <= LFSR_SEED;
    else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
  end

endmodule

// File: rtl/snake_food_spawner.sv
// Food slot manager: eats food under the head on game ticks and respawns free slots
// at random empty cells, checking body occupancy through a request/ack query.
module snake_food_spawner
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W   = DEF_GRID_W,
  parameter int unsigned GRID_H   = DEF_GRID_H,
  parameter int unsigned X_W      = DEF_X_W,
  parameter int unsigned Y_W      = DEF_Y_W,
  parameter int unsigned NUM_FOOD = 2,
  parameter int unsigned TICK_DIV = 250000
) (
  input  logic                    CLK_50M,
  input  logic                    RSTn,
  input  logic [X_W-1:0]          head_x,
  input  logic [Y_W-1:0]          head_y,
  output logic [NUM_FOOD*X_W-1:0] food_x,
  output logic [NUM_FOOD*Y_W-1:0] food_y,
  output logic [NUM_FOOD-1:0]     food_valid,
  output logic                    add_cube,
  output logic [1:0]              eat_idx,
  output logic [15:0]             eat_cnt,
  output logic                    occ_req,
  output logic [X_W-1:0]          occ_x,
  output logic [Y_W-1:0]          occ_y,
  input  logic                    occ_ack,
  input  logic                    occ_hit
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [15:0]         lfsr;
  logic [TW-1:0]       tick_cnt;
  logic                tick;
  logic [X_W-1:0]      fx [NUM_FOOD];
  logic [Y_W-1:0]      fy [NUM_FOOD];
  logic [NUM_FOOD-1:0] hit_vec;
  logic [1:0]          hit_idx;
  logic [1:0]          free_idx;
  logic [1:0]          slot_sel;
  logic [X_W-1:0]      cx;
  logic [Y_W-1:0]      cy;
  logic                clash;
  logic                cand_ok;
  logic                sel_load;
  logic                cand_load;
  logic                place;
  logic                unused_lfsr;
  spawn_state_t        state_q, state_d;

  snake_lfsr16 u_lfsr (
    .CLK_50M (CLK_50M),
    .RSTn    (RSTn),
    .lfsr    (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:X_W+Y_W];
  assign cx = lfsr[X_W-1:0];
  assign cy = lfsr[X_W+Y_W-1:X_W];

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  // Scanning from the top index down leaves the lowest matching index as the result.
  always_comb begin
    hit_vec  = '0;
    hit_idx  = '0;
    free_idx = '0;
    clash    = 1'b0;
    for (int unsigned k = 0; k < NUM_FOOD; k++) begin
      hit_vec[k] = food_valid[k] && (fx[k] == head_x) && (fy[k] == head_y);
      if (food_valid[k] && (fx[k] == cx) && (fy[k] == cy)) clash = 1'b1;
    end
    for (int unsigned k = 0; k < NUM_FOOD; k++) begin
      if (hit_vec[NUM_FOOD-1-k])     hit_idx  = 2'(NUM_FOOD - 1 - k);
      if (!food_valid[NUM_FOOD-1-k]) free_idx = 2'(NUM_FOOD - 1 - k);
    end
  end

  assign cand_ok = (cx != '0) && (cx <= X_W'(GRID_W - 2)) &&
                   (cy != '0) && (cy <= Y_W'(GRID_H - 2)) &&
                   !((cx == head_x) && (cy == head_y)) && !clash;

  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    sel_load  = 1'b0;
    cand_load = 1'b0;
    place     = 1'b0;
    occ_req   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!(&food_valid)) begin
          sel_load = 1'b1;
          state_d  = S_GEN;
        end
      end
      S_GEN: begin
        if (cand_ok) begin
          cand_load = 1'b1;
          state_d   = S_QUERY;
        end
      end
      S_QUERY: begin
        occ_req = 1'b1;
        if (occ_ack) state_d = occ_hit ? S_GEN : S_PLACE;
      end
      S_PLACE: begin
        place   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Eat clears and the PLACE write touch different slots, so both apply in one cycle.
  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      for (int unsigned k = 0; k < NUM_FOOD; k++) begin
        fx[k] <= (k == 0) ? X_W'(FOOD_RST_X) : '0;
        fy[k] <= (k == 0) ? Y_W'(FOOD_RST_Y) : '0;
      end
      food_valid <= NUM_FOOD'(1);
      slot_sel   <= '0;
      occ_x      <= '0;
      occ_y      <= '0;
      add_cube   <= 1'b0;
      eat_idx    <= '0;
      eat_cnt    <= '0;
    end else begin
      add_cube <= tick && (|hit_vec);
      if (tick && (|hit_vec)) begin
        eat_idx <= hit_idx;
        if (eat_cnt != 16'hFFFF) eat_cnt <= eat_cnt + 16'd1;
      end
      if (sel_load) slot_sel <= free_idx;
      if (cand_load) begin
        occ_x <= cx;
        occ_y <= cy;
      end
      for (int unsigned k = 0; k < NUM_FOOD; k++) begin
        if (tick && hit_vec[k]) food_valid[k] <= 1'b0;
        if (place && (slot_sel == 2'(k))) begin
          food_valid[k] <= 1'b1;
          fx[k]         <= occ_x;
          fy[k]         <= occ_y;
        end
      end
    end
  end

  always_comb begin
    food_x = '0;
    food_y = '0;
    for (int unsigned k = 0; k < NUM_FOOD; k++) begin
      food_x[k*X_W +: X_W] = fx[k];
      food_y[k*Y_W +: Y_W] = fy[k];
    end
  end

endmodule

// File: tb/tb_snake_food_spawner.sv
// Directed bench for snake_food_spawner with TICK_DIV=8 and two food slots.
module tb_snake_food_spawner;

  logic        CLK_50M = 1'b0;
  logic        RSTn    = 1'b0;
  logic [5:0]  head_x  = 6'd24;
  logic [4:0]  head_y  = 5'd10;
  logic [11:0] food_x;
  logic [9:0]  food_y;
  logic [1:0]  food_valid;
  logic        add_cube;
  logic [1:0]  eat_idx;
  logic [15:0] eat_cnt;
  logic        occ_req;
  logic [5:0]  occ_x;
  logic [4:0]  occ_y;
  logic        occ_ack = 1'b0;
  logic        occ_hit = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #10 CLK_50M = ~CLK_50M;

  snake_food_spawner #(
    .GRID_W   (40),
    .GRID_H   (30),
    .X_W      (6),
    .Y_W      (5),
    .NUM_FOOD (2),
    .TICK_DIV (8)
  ) dut (
    .CLK_50M    (CLK_50M),
    .RSTn       (RSTn),
    .head_x     (head_x),
    .head_y     (head_y),
    .food_x     (food_x),
    .food_y     (food_y),
    .food_valid (food_valid),
    .add_cube   (add_cube),
    .eat_idx    (eat_idx),
    .eat_cnt    (eat_cnt),
    .occ_req    (occ_req),
    .occ_x      (occ_x),
    .occ_y      (occ_y),
    .occ_ack    (occ_ack),
    .occ_hit    (occ_hit)
  );

  // Leaves the caller on the negedge where RSTn was released; the next posedge is edge 1.
  task automatic do_reset();
    RSTn = 1'b0;
    repeat (2) @(negedge CLK_50M);
    RSTn = 1'b1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    repeat (2) @(negedge CLK_50M);
    checks++;
    if ({food_valid, food_x, food_y} !== {2'b01, 6'd0, 6'd24, 5'd0, 5'd10}) begin
      failures++;
      $display("FAIL reset_food valid=%b x=%h y=%h exp valid=01 x=018 y=00a", food_valid, food_x, food_y);
    end
    checks++;
    if ({add_cube, eat_idx, eat_cnt, occ_req, occ_x, occ_y} !== '0) begin
      failures++;
      $display("FAIL reset_ctl add=%b idx=%0d cnt=%0d req=%b ox=%0d oy=%0d exp all 0",
               add_cube, eat_idx, eat_cnt, occ_req, occ_x, occ_y);
    end
  endtask

  // LFSR from ACE1 gives E270 (cx=48), 7138 (cx=56) rejected, then 389C -> (28,2).
  task automatic test_spawn_and_eat();
    logic extra_pulse;
    extra_pulse = 1'b0;
    head_x = 6'd24; head_y = 5'd10;
    occ_ack = 1'b1; occ_hit = 1'b0;
    do_reset();
    for (int e = 1; e <= 15; e++) begin
      @(negedge CLK_50M);
      if (e <= 3) begin
        checks++;
        if (occ_req !== 1'b0) begin
          failures++;
          $display("FAIL gen_reject edge=%0d occ_req=%b exp 0", e, occ_req);
        end
      end
      if (e == 4) begin
        checks++;
        if ({occ_req, occ_x, occ_y} !== {1'b1, 6'd28, 5'd2}) begin
          failures++;
          $display("FAIL first_query req=%b x=%0d y=%0d exp 1 28 2", occ_req, occ_x, occ_y);
        end
      end
      if (e == 5) begin
        checks++;
        if (occ_req !== 1'b0) begin
          failures++;
          $display("FAIL query_drop occ_req=%b exp 0", occ_req);
        end
      end
      if (e == 6) begin
        checks++;
        if ({food_valid, food_x[11:6], food_y[9:5]} !== {2'b11, 6'd28, 5'd2}) begin
          failures++;
          $display("FAIL spawn_place valid=%b x1=%0d y1=%0d exp 11 28 2", food_valid, food_x[11:6], food_y[9:5]);
        end
      end
      if (e == 7) begin
        checks++;
        if (add_cube !== 1'b0) begin
          failures++;
          $display("FAIL early_eat add_cube=%b exp 0", add_cube);
        end
      end
      if (e == 8) begin
        checks++;
        if ({add_cube, eat_idx, eat_cnt, food_valid} !== {1'b1, 2'd0, 16'd1, 2'b10}) begin
          failures++;
          $display("FAIL eat add=%b idx=%0d cnt=%0d valid=%b exp 1 0 1 10", add_cube, eat_idx, eat_cnt, food_valid);
        end
      end
      if (e >= 9 && add_cube !== 1'b0) extra_pulse = 1'b1;
    end
    checks++;
    if (extra_pulse || eat_cnt !== 16'd1) begin
      failures++;
      $display("FAIL eat_once extra_pulse=%b cnt=%0d exp 0 1", extra_pulse, eat_cnt);
    end
  endtask

  task automatic test_query_retry();
    logic [5:0] qx;
    logic [4:0] qy;
    logic       unstable;
    int         n;
    qx = '0; qy = '0;
    head_x = 6'd5; head_y = 5'd5;
    occ_ack = 1'b0; occ_hit = 1'b0;
    do_reset();
    for (int ep = 0; ep < 3; ep++) begin
      n = 0;
      while (occ_req !== 1'b1 && n < 64) begin
        @(negedge CLK_50M);
        n++;
      end
      checks++;
      if (n >= 64) begin
        failures++;
        $display("FAIL retry_timeout ep=%0d occ_req=%b exp 1 within 64 cycles", ep, occ_req);
      end
      qx = occ_x; qy = occ_y;
      checks++;
      if (qx < 6'd1 || qx > 6'd38 || qy < 5'd1 || qy > 5'd28 ||
          (qx == 6'd5 && qy == 5'd5) || (qx == 6'd24 && qy == 5'd10)) begin
        failures++;
        $display("FAIL cand_range ep=%0d x=%0d y=%0d exp inside 1..38/1..28 not head/slot0", ep, qx, qy);
      end
      unstable = 1'b0;
      for (int w = 0; w < 3; w++) begin
        @(negedge CLK_50M);
        if (occ_req !== 1'b1 || occ_x !== qx || occ_y !== qy) unstable = 1'b1;
      end
      checks++;
      if (unstable) begin
        failures++;
        $display("FAIL query_hold ep=%0d req=%b x=%0d y=%0d exp 1 %0d %0d", ep, occ_req, occ_x, occ_y, qx, qy);
      end
      occ_ack = 1'b1;
      occ_hit = (ep < 2);
      @(negedge CLK_50M);
      occ_ack = 1'b0;
      occ_hit = 1'b0;
      checks++;
      if (occ_req !== 1'b0 || food_valid[1] !== 1'b0) begin
        failures++;
        $display("FAIL ack_resp ep=%0d req=%b valid1=%b exp 0 0", ep, occ_req, food_valid[1]);
      end
    end
    @(negedge CLK_50M);
    checks++;
    if ({food_valid, food_x[11:6], food_y[9:5]} !== {2'b11, qx, qy}) begin
      failures++;
      $display("FAIL retry_place valid=%b x1=%0d y1=%0d exp 11 %0d %0d", food_valid, food_x[11:6], food_y[9:5], qx, qy);
    end
  endtask

  task automatic test_gen_boundary();
    logic seen;
    head_x = 6'd5; head_y = 5'd5;
    occ_ack = 1'b0; occ_hit = 1'b0;
    RSTn = 1'b0;
    force dut.lfsr = 16'h0167;
    @(negedge CLK_50M);
    RSTn = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge CLK_50M);
      if (occ_req !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL cx39_reject occ_req seen=%b exp 0", seen);
    end
    force dut.lfsr = 16'h0140;
    seen = 1'b0;
    repeat (6) begin
      @(negedge CLK_50M);
      if (occ_req !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL cx0_reject occ_req seen=%b exp 0", seen);
    end
    force dut.lfsr = 16'h0726;
    @(negedge CLK_50M);
    release dut.lfsr;
    checks++;
    if ({occ_req, occ_x, occ_y} !== {1'b1, 6'd38, 5'd28}) begin
      failures++;
      $display("FAIL edge_accept req=%b x=%0d y=%0d exp 1 38 28", occ_req, occ_x, occ_y);
    end
  endtask

  // Continues from the open query left by test_gen_boundary.
  task automatic test_reset_mid_query();
    repeat (3) @(negedge CLK_50M);
    checks++;
    if ({occ_req, occ_x, occ_y} !== {1'b1, 6'd38, 5'd28}) begin
      failures++;
      $display("FAIL query_wait req=%b x=%0d y=%0d exp 1 38 28", occ_req, occ_x, occ_y);
    end
    #3 RSTn = 1'b0;
    #1;
    checks++;
    if ({occ_req, occ_x, occ_y, add_cube, eat_cnt, food_valid, food_x, food_y} !==
        {1'b0, 6'd0, 5'd0, 1'b0, 16'd0, 2'b01, 6'd0, 6'd24, 5'd0, 5'd10}) begin
      failures++;
      $display("FAIL async_reset req=%b ox=%0d oy=%0d add=%b cnt=%0d valid=%b x=%h y=%h exp reset values",
               occ_req, occ_x, occ_y, add_cube, eat_cnt, food_valid, food_x, food_y);
    end
  endtask

  task automatic test_eat_saturate();
    head_x = 6'd24; head_y = 5'd10;
    occ_ack = 1'b1; occ_hit = 1'b0;
    do_reset();
    @(negedge CLK_50M);
    force dut.eat_cnt = 16'hFFFF;
    @(negedge CLK_50M);
    release dut.eat_cnt;
    repeat (6) @(negedge CLK_50M);
    checks++;
    if ({add_cube, eat_idx, eat_cnt} !== {1'b1, 2'd0, 16'hFFFF}) begin
      failures++;
      $display("FAIL sat_eat add=%b idx=%0d cnt=%h exp 1 0 ffff", add_cube, eat_idx, eat_cnt);
    end
    @(negedge CLK_50M);
    checks++;
    if ({add_cube, eat_cnt} !== {1'b0, 16'hFFFF}) begin
      failures++;
      $display("FAIL sat_after add=%b cnt=%h exp 0 ffff", add_cube, eat_cnt);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_spawn_and_eat();
    test_query_retry();
    test_gen_boundary();
    test_reset_mid_query();
    test_eat_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
